adq_adc_responder: RTL and testbench

ADQ_ADC_RESPONDER -- requirements
Module: adq_adc_responder

---
 rtl/adq_adc_responder.sv | 102 ++++++++++
 tb/tb_adq_adc_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adq_adc_responder.sv
// adq_adc_responder: cycle-level stand-in for a sampling ADC with a
// chip-select / start / read handshake and a fixed conversion time.
// Ports: clk, rst (async, active-high), cs, sc, rc, ain[DATA_W] in;
//        eoc, busy, dout[DATA_W], dout_valid, ovr, busy_err out.
//        Every output comes straight from a flop.
module adq_adc_responder #(
   parameter int DATA_W      = 8,
   parameter int CONV_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs,
   input  logic              sc,
   input  logic              rc,
   input  logic [DATA_W-1:0] ain,
   output logic              eoc,
   output logic              busy,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              ovr,
   output logic              busy_err
);
   typedef enum logic [2:0] {
      IDLE, SAMPLE, CONVERT, DONE, READ
   } state_t;

   localparam logic [7:0] CNT_LOAD = 8'(CONV_CYCLES - 1);

   state_t            state;
   state_t            nxt;
   logic [7:0]        cnt;
   logic              sc_q;
   logic              armed;
   logic              start_req;
   logic              rd_req;
   logic [DATA_W-1:0] sample;
   logic [DATA_W-1:0] result;

   // armed stays low after reset until sc has been seen low, so a start
   // line held high through reset release is not mistaken for an edge.
   assign start_req = cs & sc & ~sc_q & armed;
   assign rd_req    = cs & rc;

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (start_req) nxt = SAMPLE;
         SAMPLE:  nxt = CONVERT;
         CONVERT: if (cnt == 8'd0) nxt = DONE;
         DONE: begin
            if (start_req)   nxt = SAMPLE;
            else if (rd_req) nxt = READ;
         end
         READ:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Status outputs are decoded from the next state so they line up
   // with the state register instead of lagging it by a cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         sc_q       <= 1'b0;
         armed      <= 1'b0;
         sample     <= '0;
         result     <= '0;
         eoc        <= 1'b0;
         busy       <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
         ovr        <= 1'b0;
         busy_err   <= 1'b0;
      end else begin
         state      <= nxt;
         sc_q       <= sc;
         armed      <= armed | ~sc;
         eoc        <= (nxt == DONE);
         busy       <= (nxt == SAMPLE) || (nxt == CONVERT);
         dout_valid <= (nxt == READ);
         dout       <= (nxt == READ) ? result : '0;
         busy_err   <= start_req &&
                       (state == SAMPLE || state == CONVERT ||
                        state == READ);

         if (state == SAMPLE) begin
            sample <= ain;
            cnt    <= CNT_LOAD;
         end

         if (state == CONVERT) begin
            if (cnt == 8'd0) result <= sample;
            else             cnt    <= cnt - 8'd1;
         end

         if (state == DONE && start_req) ovr <= 1'b1;
         else if (state == READ)         ovr <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adq_adc_responder.sv
// tb_adq_adc_responder: directed bench with a read-data scoreboard.
// Instance u_dut uses CONV_CYCLES=16, u_dut1 uses CONV_CYCLES=1.
module tb_adq_adc_responder;
   localparam int N = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic       cs = 1'b0, sc = 1'b0, rc = 1'b0;
   logic [7:0] ain = 8'h00;
   logic       eoc, busy, dout_valid, ovr, busy_err;
   logic [7:0] dout;

   logic       cs1 = 1'b0, sc1 = 1'b0, rc1 = 1'b0;
   logic [7:0] ain1 = 8'h00;
   logic       eoc1, busy1, dout_valid1, ovr1, busy_err1;
   logic [7:0] dout1;

   int         n_chk = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         rises1 = 0;
   logic       busy1_q = 1'b0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] e0, e1;

   adq_adc_responder #(.DATA_W(8), .CONV_CYCLES(N)) u_dut (
      .clk(clk), .rst(rst), .cs(cs), .sc(sc), .rc(rc), .ain(ain),
      .eoc(eoc), .busy(busy), .dout(dout), .dout_valid(dout_valid),
      .ovr(ovr), .busy_err(busy_err)
   );

   adq_adc_responder #(.DATA_W(8), .CONV_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst), .cs(cs1), .sc(sc1), .rc(rc1), .ain(ain1),
      .eoc(eoc1), .busy(busy1), .dout(dout1),
      .dout_valid(dout_valid1), .ovr(ovr1), .busy_err(busy_err1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Read-data monitors: pop the expected value on every strobe,
   // and require dout to be zero whenever the strobe is low.
   always @(negedge clk) begin
      if (!rst) begin
         n_chk++;
         if (dout_valid) begin
            if (q0.size() == 0) begin
               n_fail++;
               $display("FAIL rd0_unexpected: dout=%0h, no read issued",
                        dout);
            end else begin
               e0 = q0.pop_front();
               if (dout !== e0) begin
                  n_fail++;
                  $display("FAIL rd0_data: got %0h expected %0h",
                           dout, e0);
               end
            end
         end else if (dout !== 8'h00) begin
            n_fail++;
            $display("FAIL rd0_idle: got %0h expected 0", dout);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         n_chk++;
         if (dout_valid1) begin
            if (q1.size() == 0) begin
               n_fail++;
               $display("FAIL rd1_unexpected: dout=%0h, no read issued",
                        dout1);
            end else begin
               e1 = q1.pop_front();
               if (dout1 !== e1) begin
                  n_fail++;
                  $display("FAIL rd1_data: got %0h expected %0h",
                           dout1, e1);
               end
            end
         end else if (dout1 !== 8'h00) begin
            n_fail++;
            $display("FAIL rd1_idle: got %0h expected 0", dout1);
         end
      end
      if (busy1 && !busy1_q) rises1++;
      busy1_q = busy1;
   end

   task automatic start(input logic [7:0] a, output int t0);
      ain = a;
      sc  = 1'b1;
      step();
      t0  = cyc;
      sc  = 1'b0;
   endtask

   task automatic wait_eoc(input int t0, input string name);
      int  n = 0;
      bit  busy_all = 1'b1;
      while (!eoc && n < 60) begin
         if (!busy) busy_all = 1'b0;
         step();
         n++;
      end
      chk({name, " eoc_seen"}, eoc, 1);
      chk({name, " latency"}, cyc - t0, N + 1);
      chk({name, " busy_during"}, busy_all, 1);
      chk({name, " busy_at_eoc"}, busy, 0);
   endtask

   task automatic rd(input logic [7:0] exp);
      q0.push_back(exp);
      rc = 1'b1;
      step();
      rc = 1'b0;
      step();
      chk("rd eoc_low", eoc, 0);
      chk("rd strobe_once", dout_valid, 0);
   endtask

   initial begin
      int t0;
      int first;

      #2 rst = 1'b1;
      #1;
      chk("reset outs",
          {eoc, busy, dout_valid, ovr, busy_err, dout}, 0);
      chk("reset outs1",
          {eoc1, busy1, dout_valid1, ovr1, busy_err1, dout1}, 0);
      step();
      step();
      #2 rst = 1'b0;
      step();
      step();

      // basic conversion
      cs = 1'b1;
      start(8'hA5, t0);
      chk("basic busy_k1", busy, 1);
      wait_eoc(t0, "basic");
      rd(8'hA5);

      // chip select gating
      cs = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sc = (i % 2 == 0);
         rc = (i % 3 == 0);
         step();
         chk("cs gate", {eoc, busy, dout_valid, ovr, busy_err}, 0);
      end
      sc = 1'b0;
      rc = 1'b0;
      step();
      cs = 1'b1;

      // rc outside DONE
      rc = 1'b1;
      repeat (3) step();
      rc = 1'b0;
      chk("rc idle", {eoc, busy}, 0);

      // overrun
      start(8'h11, t0);
      wait_eoc(t0, "ovr first");
      chk("ovr before", ovr, 0);
      start(8'h22, t0);
      chk("ovr set", ovr, 1);
      chk("ovr busy", busy, 1);
      chk("ovr eoc_drop", eoc, 0);
      wait_eoc(t0, "ovr second");
      chk("ovr held", ovr, 1);
      rd(8'h22);
      chk("ovr cleared", ovr, 0);

      // start while busy
      start(8'h3C, t0);
      repeat (6) step();
      sc = 1'b1;
      step();
      sc = 1'b0;
      chk("busy_err pulse", busy_err, 1);
      step();
      chk("busy_err once", busy_err, 0);
      wait_eoc(t0, "start busy");
      chk("start busy no_ovr", ovr, 0);
      rd(8'h3C);

      // reset mid-conversion, sc held high through release
      start(8'h77, t0);
      repeat (4) step();
      chk("pre reset busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("async reset",
          {eoc, busy, dout_valid, ovr, busy_err, dout}, 0);
      sc = 1'b1;
      step();
      step();
      #2 rst = 1'b0;
      repeat (3) begin
         step();
         chk("sc held no start", {busy, eoc}, 0);
      end
      sc = 1'b0;
      step();
      start(8'h5A, t0);
      wait_eoc(t0, "post reset");
      rd(8'h5A);

      // CONV_CYCLES=1 boundary, sc held for 10 cycles
      cs1  = 1'b1;
      ain1 = 8'h4B;
      sc1  = 1'b1;
      step();
      t0    = cyc;
      first = -1;
      for (int i = 0; i < 9; i++) begin
         step();
         if (eoc1 && first < 0) first = cyc - t0;
      end
      chk("n1 latency", first, 2);
      sc1 = 1'b0;
      step();
      chk("n1 eoc held", eoc1, 1);
      chk("n1 one conversion", rises1, 1);
      q1.push_back(8'h4B);
      rc1 = 1'b1;
      step();
      rc1 = 1'b0;
      step();
      chk("n1 eoc clear", eoc1, 0);

      step();
      step();
      chk("q0 drained", q0.size(), 0);
      chk("q1 drained", q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
